// File: rtl/wide_inv_reg.sv
// Pipelined wide bitwise inverter: d_out = ~d_in delayed by PIPE_STAGES clocks.
// rdy rises once the pipeline has refilled after reset and then stays high.
module wide_inv_reg #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned PIPE_STAGES = 2
) (
  input  logic             clock,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_in,
  output logic [WIDTH-1:0] d_out,
  output logic             rdy
);

  localparam int unsigned CNT_W = $clog2(PIPE_STAGES + 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(PIPE_STAGES);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;

  // Fill counter saturates at the pipeline depth.
  always_comb begin
    cnt_nxt = cnt;
    if (cnt != FULL) begin
      cnt_nxt = cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      rdy <= 1'b0;
    end else begin
      cnt <= cnt_nxt;
      rdy <= (cnt_nxt == FULL);
    end
  end

  // Inversion sits on entry to the last stage so d_out is purely registered.
  if (PIPE_STAGES == 1) begin : g_single
    always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
        d_out <= '0;
      end else begin
        d_out <= ~d_in;
      end
    end
  end else begin : g_multi
    logic [WIDTH-1:0] stage [PIPE_STAGES-1];

    always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
        for (int i = 0; i < int'(PIPE_STAGES) - 1; i++) begin
          stage[i] <= '0;
        end
        d_out <= '0;
      end else begin
        stage[0] <= d_in;
        for (int i = 1; i < int'(PIPE_STAGES) - 1; i++) begin
          stage[i] <= stage[i-1];
        end
        d_out <= ~stage[PIPE_STAGES-2];
      end
    end
  end

endmodule

// File: tb/tb_wide_inv_reg.sv
// Randomized self-checking bench for wide_inv_reg across four parameterizations
// against a history-queue reference model.
module tb_wide_inv_reg;

  logic        clock = 1'b0;
  logic        rst;
  logic [31:0] din_a, din_b, din_c, dout_a, dout_b, dout_c;
  logic [7:0]  din_w, dout_w;
  logic        rdy_a, rdy_b, rdy_c, rdy_w;

  int n_checks = 0;
  int n_errors = 0;
  int n_edges  = 0;

  // Inputs seen on each rising edge since the last reset release.
  logic [31:0] q_a[$];
  logic [31:0] q_b[$];
  logic [31:0] q_c[$];
  logic [7:0]  q_w[$];

  logic [31:0] sweep_in  [10];
  logic [31:0] sweep_exp [10];

  always #5 clock = ~clock;

  wide_inv_reg #(.WIDTH(32), .PIPE_STAGES(2)) u_dut_a (
    .clock(clock), .rst(rst), .d_in(din_a), .d_out(dout_a), .rdy(rdy_a));
  wide_inv_reg #(.WIDTH(32), .PIPE_STAGES(1)) u_dut_b (
    .clock(clock), .rst(rst), .d_in(din_b), .d_out(dout_b), .rdy(rdy_b));
  wide_inv_reg #(.WIDTH(32), .PIPE_STAGES(4)) u_dut_c (
    .clock(clock), .rst(rst), .d_in(din_c), .d_out(dout_c), .rdy(rdy_c));
  wide_inv_reg #(.WIDTH(8), .PIPE_STAGES(2)) u_dut_w (
    .clock(clock), .rst(rst), .d_in(din_w), .d_out(dout_w), .rdy(rdy_w));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    if (rst) begin
      check("rst_dout_a", dout_a, 32'h0);
      check("rst_rdy_a", 32'(rdy_a), 32'h0);
      check("rst_dout_b", dout_b, 32'h0);
      check("rst_rdy_b", 32'(rdy_b), 32'h0);
      check("rst_dout_c", dout_c, 32'h0);
      check("rst_rdy_c", 32'(rdy_c), 32'h0);
      check("rst_dout_w", {24'h0, dout_w}, 32'h0);
      check("rst_rdy_w", 32'(rdy_w), 32'h0);
    end else begin
      check("rdy_a", 32'(rdy_a), 32'(n_edges >= 2));
      check("rdy_b", 32'(rdy_b), 32'(n_edges >= 1));
      check("rdy_c", 32'(rdy_c), 32'(n_edges >= 4));
      check("rdy_w", 32'(rdy_w), 32'(n_edges >= 2));
      if (n_edges >= 2) check("dout_a", dout_a, ~q_a[n_edges-2]);
      if (n_edges >= 1) check("dout_b", dout_b, ~q_b[n_edges-1]);
      if (n_edges >= 4) check("dout_c", dout_c, ~q_c[n_edges-4]);
      if (n_edges >= 2) check("dout_w", {24'h0, dout_w}, {24'h0, ~q_w[n_edges-2]});
    end
  endtask

  task automatic model_clear();
    n_edges = 0;
    q_a.delete();
    q_b.delete();
    q_c.delete();
    q_w.delete();
  endtask

  task automatic rand_side();
    din_b = $urandom;
    din_c = $urandom;
    din_w = 8'($urandom);
  endtask

  // One rising edge: record sampled inputs, then check just after the edge.
  task automatic step();
    @(posedge clock);
    if (!rst) begin
      n_edges++;
      q_a.push_back(din_a);
      q_b.push_back(din_b);
      q_c.push_back(din_c);
      q_w.push_back(din_w);
    end
    #1;
    check_all();
  endtask

  initial begin
    sweep_in  = '{32'hffffffff, 32'hffff0000, 32'h0000ffff, 32'h55555555, 32'haaaaaaaa,
                  32'h11111111, 32'h22222222, 32'h44444444, 32'h88888888, 32'h00000000};
    sweep_exp = '{32'h00000000, 32'h0000ffff, 32'hffff0000, 32'haaaaaaaa, 32'h55555555,
                  32'heeeeeeee, 32'hdddddddd, 32'hbbbbbbbb, 32'h77777777, 32'hffffffff};

    rst   = 1'b1;
    din_a = 32'h12345678;
    din_b = 32'h12345678;
    din_c = 32'h12345678;
    din_w = 8'h5a;
    model_clear();
    #1;
    check_all();
    for (int i = 0; i < 3; i++) step();

    // Release with zero input; rdy after the second edge.
    rst   = 1'b0;
    din_a = 32'h0;
    step();
    check("ready_edge1", 32'(rdy_a), 32'h0);
    step();
    check("ready_edge2", 32'(rdy_a), 32'h1);
    check("ready_dout", dout_a, 32'hffffffff);
    for (int i = 0; i < 20; i++) begin
      din_a = $urandom;
      rand_side();
      step();
      check("ready_hold", 32'(rdy_a), 32'h1);
    end

    din_w = 8'h5a;
    step();
    rand_side();
    step();
    check("w8_5a", {24'h0, dout_w}, 32'h000000a5);

    // Directed pattern sweep with the literal expected table.
    for (int i = 0; i < 10; i++) begin
      din_a = sweep_in[i];
      rand_side();
      step();
      if (i >= 1) check("sweep", dout_a, sweep_exp[i-1]);
    end
    rand_side();
    step();
    check("sweep", dout_a, sweep_exp[9]);

    // Walking one across every bit.
    for (int b = 0; b < 32; b++) begin
      din_a = 32'h1 << b;
      rand_side();
      step();
    end
    for (int i = 0; i < 2; i++) begin
      din_a = $urandom;
      step();
    end

    // Mid-run asynchronous reset pulse shorter than a cycle.
    for (int i = 0; i < 6; i++) begin
      din_a = $urandom;
      rand_side();
      step();
    end
    rst = 1'b1;
    model_clear();
    #1;
    check_all();
    #1;
    rst = 1'b0;
    for (int i = 0; i < 30; i++) begin
      din_a = $urandom;
      rand_side();
      step();
      if (i == 0) check("refill_edge1", 32'(rdy_a), 32'h0);
      if (i == 1) check("refill_edge2", 32'(rdy_a), 32'h1);
      if (i == 3) check("refill_p4", 32'(rdy_c), 32'h1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
